// File: rtl/dbg_pkg.sv
// dbg_pkg: shared state encoding, halt-cause codes and dump-index offsets
package dbg_pkg;
    typedef enum logic [2:0] {S_IDLE, S_RUN, S_SEL, S_CAP, S_SEND, S_DONE} state_t;
    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_BP   = 2'd1;
    localparam logic [1:0] CAUSE_TO   = 2'd2;
    localparam int OFF_PC  = 0;
    localparam int OFF_CNT = 1;
endpackage

// File: rtl/dbg_bp_match.sv
// dbg_bp_match: PC breakpoint comparators with lowest-index-wins priority
module dbg_bp_match #(
    parameter int XLEN   = 32,
    parameter int NUM_BP = 4
) (
    input  logic [XLEN-1:0]        i_pc,
    input  logic                   i_pc_valid,
    input  logic [NUM_BP*XLEN-1:0] i_bp_addr,
    input  logic [NUM_BP-1:0]      i_bp_en,
    output logic                   o_hit,
    output logic [2:0]             o_hit_id
);
    // scan high to low so the lowest matching index is the one left standing
    always_comb begin
        o_hit    = 1'b0;
        o_hit_id = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (i_pc_valid && i_bp_en[i] && i_pc == i_bp_addr[i*XLEN +: XLEN]) begin
                o_hit    = 1'b1;
                o_hit_id = 3'(i);
            end
        end
    end
endmodule

// File: rtl/dbg_halt_ctrl.sv
// dbg_halt_ctrl: breakpoint/timeout halt controller with register-file dump
module dbg_halt_ctrl
    import dbg_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NUM_BP = 4,
    parameter int NREGS  = 32,
    parameter int CW     = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic                   i_start,
    input  logic                   i_clear,
    input  logic [XLEN-1:0]        i_pc,
    input  logic                   i_pc_valid,
    input  logic [NUM_BP*XLEN-1:0] i_bp_addr,
    input  logic [NUM_BP-1:0]      i_bp_en,
    input  logic [CW-1:0]          i_cycle_limit,
    output logic                   o_halt,
    output logic [4:0]             o_reg_sel,
    input  logic [XLEN-1:0]        i_reg_data,
    output logic                   o_dump_valid,
    input  logic                   i_dump_ready,
    output logic [5:0]             o_dump_idx,
    output logic [XLEN-1:0]        o_dump_data,
    output logic [1:0]             o_halt_cause,
    output logic [2:0]             o_hit_id,
    output logic                   o_done
);
    localparam logic [5:0] IDX_PC  = 6'(NREGS + OFF_PC);
    localparam logic [5:0] IDX_CNT = 6'(NREGS + OFF_CNT);

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_hpc;
    logic [XLEN-1:0] r_data;
    logic [5:0]      r_idx;
    logic [1:0]      r_cause;
    logic [2:0]      r_hit_id;

    logic            w_bp_hit;
    logic [2:0]      w_bp_id;
    logic [CW-1:0]   w_cnt_inc;
    logic            w_run_ret;
    logic            w_timeout;
    logic            w_halt_dec;
    logic            w_hs;
    logic [5:0]      w_idx_nxt;

    dbg_bp_match #(.XLEN(XLEN), .NUM_BP(NUM_BP)) u_match (
        .i_pc      (i_pc),
        .i_pc_valid(w_run_ret),
        .i_bp_addr (i_bp_addr),
        .i_bp_en   (i_bp_en),
        .o_hit     (w_bp_hit),
        .o_hit_id  (w_bp_id)
    );

    assign w_run_ret  = r_state == S_RUN && i_pc_valid;
    assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
    assign w_timeout  = i_cycle_limit != '0 && w_cnt_inc == i_cycle_limit;
    assign w_halt_dec = w_run_ret && (w_bp_hit || w_timeout);
    assign w_hs       = r_state == S_SEND && i_dump_ready;
    assign w_idx_nxt  = r_idx + 6'd1;

    // state register
    always_ff @(posedge i_clk) begin
        if (!i_rstn) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // next-state: the last two dump words skip SEL/CAP and stay in SEND
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = i_start ? S_RUN : S_IDLE;
            S_RUN:   w_state_nxt = w_halt_dec ? S_SEL : S_RUN;
            S_SEL:   w_state_nxt = S_CAP;
            S_CAP:   w_state_nxt = S_SEND;
            S_SEND:  w_state_nxt = !i_dump_ready ? S_SEND :
                                   r_idx == IDX_CNT ? S_DONE :
                                   w_idx_nxt >= IDX_PC ? S_SEND : S_SEL;
            S_DONE:  w_state_nxt = i_clear ? S_IDLE : S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // datapath: retire counter, halt capture and dump word staging
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_cnt    <= '0;
            r_hpc    <= '0;
            r_data   <= '0;
            r_idx    <= '0;
            r_cause  <= CAUSE_NONE;
            r_hit_id <= '0;
        end else begin
            if (r_state == S_IDLE && i_start) r_cnt <= '0;
            if (w_run_ret) r_cnt <= w_cnt_inc;
            if (w_halt_dec) begin
                r_hpc    <= i_pc;
                r_cause  <= w_bp_hit ? CAUSE_BP : CAUSE_TO;
                r_hit_id <= w_bp_hit ? w_bp_id : 3'd0;
                r_idx    <= '0;
            end
            if (r_state == S_CAP) r_data <= (r_idx == '0) ? '0 : i_reg_data;
            if (w_hs) begin
                r_idx <= w_idx_nxt;
                if (w_idx_nxt == IDX_PC) r_data <= r_hpc;
                else if (w_idx_nxt == IDX_CNT) r_data <= XLEN'(r_cnt);
            end
            if (r_state == S_DONE && i_clear) begin
                r_cause  <= CAUSE_NONE;
                r_hit_id <= '0;
            end
        end
    end

    // outputs decoded from state and staged registers
    always_comb begin
        o_halt       = r_state inside {S_SEL, S_CAP, S_SEND, S_DONE};
        o_done       = r_state == S_DONE;
        o_dump_valid = r_state == S_SEND;
        o_reg_sel    = r_idx[4:0];
        o_dump_idx   = r_idx;
        o_dump_data  = r_data;
        o_halt_cause = r_cause;
        o_hit_id     = r_hit_id;
    end
endmodule

// File: tb/tb_dbg_halt_ctrl.sv
// tb_dbg_halt_ctrl: randomized retire/dump stimulus checked against a behavioural model
module tb_dbg_halt_ctrl;
    logic         clk = 1'b0;
    logic         rstn, start, clear, pc_valid, dump_ready;
    logic [31:0]  pc, reg_data;
    logic [127:0] bp_addr;
    logic [3:0]   bp_en;
    logic [15:0]  cycle_limit;
    logic         halt, dump_valid, done;
    logic [4:0]   reg_sel;
    logic [5:0]   dump_idx;
    logic [31:0]  dump_data;
    logic [1:0]   halt_cause;
    logic [2:0]   hit_id;
    logic [31:0]  rf [32];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) reg_data <= rf[reg_sel];

    dbg_halt_ctrl dut (
        .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_clear(clear),
        .i_pc(pc), .i_pc_valid(pc_valid), .i_bp_addr(bp_addr), .i_bp_en(bp_en),
        .i_cycle_limit(cycle_limit), .o_halt(halt), .o_reg_sel(reg_sel),
        .i_reg_data(reg_data), .o_dump_valid(dump_valid), .i_dump_ready(dump_ready),
        .o_dump_idx(dump_idx), .o_dump_data(dump_data), .o_halt_cause(halt_cause),
        .o_hit_id(hit_id), .o_done(done)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset();
        check("rst_halt", 32'(halt), 32'd0);
        check("rst_reg_sel", 32'(reg_sel), 32'd0);
        check("rst_valid", 32'(dump_valid), 32'd0);
        check("rst_idx", 32'(dump_idx), 32'd0);
        check("rst_data", dump_data, 32'd0);
        check("rst_cause", 32'(halt_cause), 32'd0);
        check("rst_hit_id", 32'(hit_id), 32'd0);
        check("rst_done", 32'(done), 32'd0);
    endtask

    task automatic run_scn(input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2,
                           input logic [31:0] b3, input logic [3:0] en, input logic [15:0] lim,
                           input int pmode, input int stall_idx, input int abort_idx);
        logic [31:0] bps [4];
        logic [31:0] exp_w [34];
        logic [31:0] p, hpc, pend_d;
        logic [5:0]  pend_i;
        logic [15:0] cnt;
        logic [1:0]  ecause;
        logic [2:0]  eid;
        logic        halted, v, rdy, pend;
        int k, cyc, w, stall_n, hit_i;
        bps = '{b0, b1, b2, b3};
        bp_addr = {b3, b2, b1, b0};
        bp_en = en;
        cycle_limit = lim;
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("run_entry", 32'(halt), 32'd0);
        cnt = '0; halted = 1'b0; k = 0; cyc = 0; ecause = 2'd0; eid = 3'd0; hpc = '0;
        while (!halted && cyc < 20000) begin
            v = ($urandom % 4) != 0;
            if (pmode == 0) p = v ? 32'(4 * (k + 1)) : $urandom;
            else p = 32'h100 + 32'(4 * $urandom_range(0, 15));
            pc = p;
            pc_valid = v;
            if (v) begin
                k++;
                cnt = (cnt == 16'hffff) ? cnt : cnt + 16'd1;
                hit_i = -1;
                for (int i = 0; i < 4; i++) if (hit_i < 0 && en[i] && p == bps[i]) hit_i = i;
                if (hit_i >= 0) begin
                    halted = 1'b1; ecause = 2'd1; eid = 3'(hit_i); hpc = p;
                end else if (lim != 0 && cnt == lim) begin
                    halted = 1'b1; ecause = 2'd2; hpc = p;
                end
            end
            tick();
            cyc++;
            check("halt_run", 32'(halt), 32'(halted));
        end
        pc_valid = 1'b0;
        check("run_bound", 32'(halted), 32'd1);
        for (int i = 0; i < 32; i++) exp_w[i] = (i == 0) ? 32'd0 : rf[i];
        exp_w[32] = hpc;
        exp_w[33] = 32'(cnt);
        w = 0; cyc = 0; stall_n = 0; pend = 1'b0; pend_i = '0; pend_d = '0;
        while (w < 34 && cyc < 3000) begin
            if (pend) begin
                check("hold_valid", 32'(dump_valid), 32'd1);
                check("hold_idx", 32'(dump_idx), 32'(pend_i));
                check("hold_data", dump_data, pend_d);
            end
            check("halt_dump", 32'(halt), 32'd1);
            check("done_dump", 32'(done), 32'd0);
            if (dump_valid && abort_idx >= 0 && dump_idx == 6'(abort_idx)) begin
                rstn = 1'b0; dump_ready = 1'b0; start = 1'b0; clear = 1'b0;
                tick();
                check_reset();
                rstn = 1'b1;
                return;
            end
            rdy = ($urandom % 3) != 0;
            if (dump_valid && dump_idx == 6'(stall_idx) && stall_n < 5) begin
                rdy = 1'b0;
                stall_n++;
            end
            dump_ready = rdy;
            pc_valid = $urandom % 2;
            pc = $urandom;
            start = ($urandom % 8) == 0;
            clear = ($urandom % 8) == 0;
            if (dump_valid && rdy) begin
                check("word_idx", 32'(dump_idx), 32'(w));
                check("word_data", dump_data, exp_w[w]);
                w++;
                pend = 1'b0;
            end else begin
                pend = dump_valid;
                pend_i = dump_idx;
                pend_d = dump_data;
            end
            tick();
            cyc++;
        end
        start = 1'b0; clear = 1'b0; dump_ready = 1'b0; pc_valid = 1'b0;
        check("dump_bound", 32'(w), 32'd34);
        check("done_set", 32'(done), 32'd1);
        check("done_halt", 32'(halt), 32'd1);
        check("done_valid", 32'(dump_valid), 32'd0);
        check("cause", 32'(halt_cause), 32'(ecause));
        if (ecause == 2'd1) check("hit_id", 32'(hit_id), 32'(eid));
        pc_valid = 1'b1;
        start = 1'b1;
        tick();
        pc_valid = 1'b0;
        start = 1'b0;
        check("done_hold", 32'(done), 32'd1);
        check("cause_hold", 32'(halt_cause), 32'(ecause));
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_halt", 32'(halt), 32'd0);
        check("clr_done", 32'(done), 32'd0);
        check("clr_cause", 32'(halt_cause), 32'd0);
    endtask

    task automatic rand_scn(input int stall_idx, input int abort_idx);
        logic [31:0] b [4];
        logic [3:0]  en;
        logic [15:0] lim;
        for (int i = 0; i < 4; i++) b[i] = 32'h100 + 32'(4 * $urandom_range(0, 15));
        en = 4'($urandom);
        lim = ($urandom % 2) ? 16'($urandom_range(1, 60)) : 16'd0;
        if (lim == 0) en[0] = 1'b1;
        run_scn(b[0], b[1], b[2], b[3], en, lim, 1, stall_idx, abort_idx);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; start = 1'b0; clear = 1'b0; pc_valid = 1'b0; dump_ready = 1'b0;
        pc = '0; bp_addr = '0; bp_en = '0; cycle_limit = '0;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        tick();
        tick();
        check_reset();
        rstn = 1'b1;
        bp_addr = {4{32'h40}};
        bp_en = 4'hf;
        cycle_limit = 16'd1;
        for (int i = 0; i < 4; i++) begin
            pc = 32'h40; pc_valid = 1'b1; clear = i[0];
            tick();
            check("idle_ignore", 32'(halt), 32'd0);
        end
        pc_valid = 1'b0; clear = 1'b0;
        run_scn(32'h48, 32'h0, 32'h0, 32'h0, 4'b0001, 16'd0, 0, -1, -1);
        run_scn(32'h0, 32'h0, 32'h0, 32'h0, 4'b0000, 16'd1000, 0, -1, -1);
        run_scn(32'h0, 32'h100, 32'h0, 32'h100, 4'b1010, 16'd64, 0, -1, -1);
        rand_scn(7, -1);
        rand_scn(-1, 10);
        rand_scn(-1, -1);
        for (int t = 0; t < 6; t++) rand_scn($urandom_range(0, 33), -1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dbg_halt_ctrl.md
DBG_HALT_CTRL -- requirements
Module: dbg_halt_ctrl

Interface
REQ-001 Parameter XLEN, default 32, data/PC width.
REQ-002 Parameter NUM_BP, default 4, number of PC breakpoint comparators (1..8).
REQ-003 Parameter NREGS, default 32, register-file entries dumped (power of 2, max 32).
REQ-004 Parameter CW, default 16, retire-counter width.
REQ-005 clk  in  1  single clock, all state updates on rising edge.
REQ-006 rstn  in  1  reset, synchronous and active-low.
REQ-007 start  in  1  arm pulse; ignored outside IDLE.
REQ-008 clear  in  1  return from DONE to IDLE; ignored elsewhere.
REQ-009 pc  in  XLEN  PC of the instruction retiring this cycle.
REQ-010 pc_valid  in  1  retire strobe qualifying pc.
REQ-011 bp_addr  in  NUM_BP*XLEN  breakpoint addresses, entry i at bits [i*XLEN +: XLEN].
REQ-012 bp_en  in  NUM_BP  per-breakpoint enable.
REQ-013 cycle_limit  in  CW  retire limit; 0 = unlimited.
REQ-014 halt  out  1  stalls the CPU; high from halt decision until clear.
REQ-015 reg_sel  out  5  register-file read select.
REQ-016 reg_data  in  XLEN  register-file read data, valid one cycle after reg_sel.
REQ-017 dump_valid / dump_ready  out / in  1 / 1  dump-word handshake.
REQ-018 dump_idx  out  6  word index: 0..NREGS-1 registers, NREGS = halt PC, NREGS+1 = retire count.
REQ-019 dump_data  out  XLEN  dump word.
REQ-020 halt_cause  out  2  0 none, 1 breakpoint, 2 timeout.
REQ-021 hit_id  out  3  index of matching breakpoint.
REQ-022 done  out  1  dump complete, held until clear.

Function
REQ-023 States IDLE, RUN, SEL, CAP, SEND, DONE; IDLE->RUN on start, counter cleared.
REQ-024 In RUN, each pc_valid increments the CW-bit counter, saturating at all-ones.
REQ-025 Breakpoint hit: pc_valid, bp_en[i], pc==bp_addr[i]; lowest i wins; halt_cause<=1, hit_id<=i, halted PC<=pc.
REQ-026 Timeout: cycle_limit!=0 and incremented count == cycle_limit; halt_cause<=2, halted PC<=pc.
REQ-027 Breakpoint and timeout in the same cycle: breakpoint has priority; count still records the retire.
REQ-028 On halt decision: halt asserts next cycle, idx<=0, state->SEL.
REQ-029 SEL: reg_sel=idx, one cycle ->CAP; CAP: dump_data<=reg_data (forced 0 for idx 0), dump_valid<=1, ->SEND.
REQ-030 Words NREGS and NREGS+1 bypass SEL/CAP and load halted PC / counter (zero-extended) directly into SEND.
REQ-031 SEND: dump_valid, dump_idx, dump_data held stable until dump_ready; on handshake idx++, next word or DONE after idx NREGS+1.
REQ-032 DONE: done=1, halt=1, halt_cause/hit_id held; clear ->IDLE, halt, done, halt_cause drop next cycle.
REQ-033 pc_valid outside RUN is ignored; start/clear outside their states are ignored.

Reset
REQ-034 rstn low at a clock edge: state IDLE, counter 0, halt 0, reg_sel 0, dump_valid 0, dump_idx 0, dump_data 0, halt_cause 0, hit_id 0, done 0.
REQ-035 Reset mid-RUN or mid-dump aborts immediately; no partial word retained.

Structure
REQ-036 State encoding, halt_cause codes and dump-index offsets live in shared package dbg_pkg.
REQ-037 One sub-module dbg_bp_match: NUM_BP comparators plus lowest-index priority encoder, combinational.

Verification
REQ-038 bp0=0x00000048 enabled, 18 retires ending at 0x48 -> halt_cause 1, hit_id 0, 34 words, word 0 = 0, word 32 = 0x48, word 33 = 18.
REQ-039 No breakpoints, cycle_limit=1000 -> halt on 1000th retire, halt_cause 2, word 33 = 1000.
REQ-040 bp1 and bp3 both 0x100, timeout on same retire -> halt_cause 1, hit_id 1.
REQ-041 dump_ready low 5 cycles during word 7 -> dump_data/dump_idx stable, no word skipped or repeated.
REQ-042 rstn low during SEND of word 10 -> all outputs at reset values next cycle; new start completes a full 34-word dump.
